// File: rtl/counter_credit_arbiter_if.sv
// rtl/counter_credit_arbiter_if.sv - consumer debit requests and credit return channel
interface counter_credit_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_amt;
  logic [NREQ-1:0]    gnt;
  logic               ret_valid;
  logic [AW-1:0]      ret_amt;
  logic               ret_ready;

  modport master (
    output req, req_amt, ret_valid, ret_amt,
    input  gnt, ret_ready
  );

  modport slave (
    input  req, req_amt, ret_valid, ret_amt,
    output gnt, ret_ready
  );
endinterface

// File: rtl/counter_credit_arbiter.sv
// rtl/counter_credit_arbiter.sv - round-robin credit-pool arbiter around an external up/down counter
module counter_credit_arbiter #(
  parameter int NREQ         = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int VW           = 4,
  parameter int AW           = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  counter_credit_arbiter_if.slave     bus,
  input  logic [VW-1:0]               cfg_credits,
  input  logic                        cfg_reload,
  input  logic [VW-1:0]               cnt_value,
  output logic                        cnt_reinit,
  output logic [VW-1:0]               cnt_initial_value,
  output logic                        cnt_incr_valid,
  output logic [AW-1:0]               cnt_incr,
  output logic                        cnt_decr_valid,
  output logic [AW-1:0]               cnt_decr,
  output logic                        busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = VW + 1;
  localparam logic [CW-1:0] POOL_MAX = CW'((1 << VW) - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] head_q, head_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [AW-1:0]   amt [NREQ];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   dec_amt;
  logic            head_found, byp_found;
  logic [PW-1:0]   head_idx, byp_idx;
  logic [SW-1:0]   starve_eff;
  logic [CW-1:0]   ret_sum;
  logic            ret_rdy;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      amt[i]  = bus.req_amt[i*AW +: AW];
      elig[i] = bus.req[i] & (VW'(amt[i]) <= cnt_value);
    end
  end

  // Head is the first requester from rr_ptr; bypass candidates follow it in RR order.
  always_comb begin
    head_found = 1'b0;
    head_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!head_found && bus.req[wrap_add(rr_ptr_q, k)]) begin
        head_found = 1'b1;
        head_idx   = wrap_add(rr_ptr_q, k);
      end
    end
    byp_found = 1'b0;
    byp_idx   = '0;
    for (int k = 1; k < NREQ; k++) begin
      if (!byp_found && elig[wrap_add(head_idx, k)]) begin
        byp_found = 1'b1;
        byp_idx   = wrap_add(head_idx, k);
      end
    end
    starve_eff = (head_idx == head_q) ? starve_q : '0;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    head_d     = head_q;
    starve_d   = starve_q;
    gnt        = '0;
    dec_amt    = '0;
    ret_sum    = '0;
    ret_rdy    = 1'b0;
    cnt_reinit = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      state_d = ST_INIT;
    end else if (state_q == ST_INIT) begin
      cnt_reinit = 1'b1;
      busy       = 1'b1;
      state_d    = ST_RUN;
    end else if (cfg_reload) begin
      state_d = ST_INIT;
    end else begin
      if (!head_found) begin
        starve_d = '0;
      end else begin
        head_d   = head_idx;
        starve_d = starve_eff;
        if (elig[head_idx]) begin
          gnt[head_idx] = 1'b1;
          dec_amt       = amt[head_idx];
          rr_ptr_d      = wrap_add(head_idx, 1);
          starve_d      = '0;
        end else if (starve_eff < SW'(STARVE_LIMIT) && byp_found) begin
          gnt[byp_idx] = 1'b1;
          dec_amt      = amt[byp_idx];
          starve_d     = starve_eff + SW'(1);
        end
      end
      // Same-cycle debit is subtracted first so the pool can never exceed its maximum.
      ret_sum = {1'b0, cnt_value} - CW'(dec_amt) + CW'(bus.ret_amt);
      ret_rdy = (ret_sum <= POOL_MAX);
    end
  end

  assign bus.gnt           = gnt;
  assign bus.ret_ready     = ret_rdy;
  assign cnt_initial_value = cfg_credits;
  assign cnt_decr_valid    = |gnt;
  assign cnt_decr          = dec_amt;
  assign cnt_incr_valid    = bus.ret_valid & ret_rdy;
  assign cnt_incr          = (bus.ret_valid & ret_rdy) ? bus.ret_amt : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      rr_ptr_q <= '0;
      head_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      head_q   <= head_d;
      starve_q <= starve_d;
    end
  end
endmodule
